divider_sequencer: RTL and testbench

//   Iterative unsigned divider controller that time-multiplexes one restoring divide step.
//   It runs DIVIDENDLEN steps, one quotient bit per step, MSB first.

---
 rtl/divider_sequencer.sv | 141 ++++++++++++++
 tb/tb_divider_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - iterative restoring unsigned divider, one quotient bit per clock
module divider_sequencer #(
    parameter int DIVIDENDLEN = 4,
    parameter int DIVISORLEN  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIVIDENDLEN-1:0] dividend,
    input  logic [DIVISORLEN-1:0]  divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIVIDENDLEN-1:0] quotient,
    output logic [DIVISORLEN-1:0]  remainder,
    output logic                   div_by_zero,
    output logic                   busy
);

    localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN - 1;
    localparam int CNTW        = (DIVIDENDLEN > 1) ? $clog2(DIVIDENDLEN) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [DATAPATHLEN-1:0] rem_q, rem_d;
    logic [DIVIDENDLEN-1:0] q_q, q_d;
    logic [DIVISORLEN-1:0]  dvs_q, dvs_d;
    logic                   dbz_q, dbz_d;

    // Result registers are separate from the working registers so the data
    // outputs keep the last delivered result while the next operation runs.
    logic [DIVIDENDLEN-1:0] quo_out_q, quo_out_d;
    logic [DIVISORLEN-1:0]  rem_out_q, rem_out_d;
    logic                   dbz_out_q, dbz_out_d;

    logic [DATAPATHLEN-1:0] trial;

    // Shifted divisor for the current step, at full datapath width so no bits are lost.
    always_comb begin
        trial = DATAPATHLEN'(dvs_q) << cnt_q;
    end

    // Next-state logic: accept, one compare/subtract per RUN cycle, result handoff.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        dbz_d     = dbz_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_out_d = dbz_out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d = DATAPATHLEN'(dividend);
                    dvs_d = divisor;
                    q_d   = '0;
                    if (divisor != '0) begin
                        cnt_d   = CNTW'(DIVIDENDLEN - 1);
                        dbz_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        // Divide by zero bypasses the step loop entirely.
                        q_d       = '1;
                        dbz_d     = 1'b1;
                        quo_out_d = '1;
                        rem_out_d = dividend[DIVISORLEN-1:0];
                        dbz_out_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (rem_q >= trial) begin
                    rem_d        = rem_q - trial;
                    q_d[cnt_q]   = 1'b1;
                end else begin
                    q_d[cnt_q]   = 1'b0;
                end
                if (cnt_q == '0) begin
                    quo_out_d = q_d;
                    rem_out_d = rem_d[DIVISORLEN-1:0];
                    dbz_out_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            dbz_q     <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            dbz_q     <= dbz_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    // Handshake and status outputs decode from state only.
    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        out_valid   = (state_q == ST_DONE);
        busy        = (state_q != ST_IDLE);
        quotient    = quo_out_q;
        remainder   = rem_out_q;
        div_by_zero = dbz_out_q;
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - self-checking bench for divider_sequencer against an arithmetic model
module tb_divider_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] dividend = '0;
    logic [1:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       div_by_zero;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic       mon_en = 1'b0;
    logic [3:0] exp_q = '0;
    logic [1:0] exp_r = '0;
    logic       exp_z = 1'b0;
    logic [3:0] held_q = '0;
    logic [1:0] held_r = '0;
    logic       held_z = 1'b0;

    divider_sequencer #(.DIVIDENDLEN(4), .DIVISORLEN(2)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Compare process: while a result is presented it must equal the model's
    // answer; otherwise the data outputs must keep the last delivered result.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_vs_ready", int'(busy), int'(!in_ready));
            if (out_valid) begin
                check("mon_quotient", quotient, exp_q);
                check("mon_remainder", remainder, exp_r);
                check("mon_dbz", div_by_zero, exp_z);
                held_q = exp_q;
                held_r = exp_r;
                held_z = exp_z;
            end else begin
                check("hold_quotient", quotient, held_q);
                check("hold_remainder", remainder, held_r);
                check("hold_dbz", div_by_zero, held_z);
            end
        end
    end

    task automatic model(input logic [3:0] dvd, input logic [1:0] dvs,
                         output logic [3:0] q, output logic [1:0] r, output logic z);
        if (dvs == 2'd0) begin
            q = 4'hF;
            r = dvd[1:0];
            z = 1'b1;
        end else begin
            q = 4'(dvd / dvs);
            r = 2'(dvd % dvs);
            z = 1'b0;
        end
    endtask

    task automatic do_op(input logic [3:0] dvd, input logic [1:0] dvs, input int hold,
                         input logic [3:0] eq, input logic [1:0] er, input logic ez);
        int n;
        int elat;
        exp_q = eq;
        exp_r = er;
        exp_z = ez;
        elat = (dvs == 2'd0) ? 0 : 4;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor = dvs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            in_valid = 1'($urandom);
            dividend = 4'($urandom);
            divisor = 2'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", n, elat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [3:0] mq;
        logic [1:0] mr;
        logic       mz;
        logic [3:0] rd;
        logic [1:0] rv;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        mon_en = 1'b1;

        do_op(4'd10, 2'd3, 0, 4'd3, 2'd1, 1'b0);
        do_op(4'd15, 2'd1, 0, 4'd15, 2'd0, 1'b0);
        do_op(4'd2, 2'd3, 0, 4'd0, 2'd2, 1'b0);
        do_op(4'd9, 2'd0, 0, 4'hF, 2'd1, 1'b1);
        do_op(4'd13, 2'd2, 5, 4'd6, 2'd1, 1'b0);

        // Reset during the second RUN step.
        exp_q = 4'd5;
        exp_r = 2'd1;
        exp_z = 1'b0;
        in_valid = 1'b1;
        dividend = 4'd11;
        divisor = 2'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        held_q = '0;
        held_r = '0;
        held_z = 1'b0;
        reset = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        do_op(4'd7, 2'd3, 0, 4'd2, 2'd1, 1'b0);

        for (int d = 0; d < 16; d++) begin
            for (int v = 0; v < 4; v++) begin
                model(4'(d), 2'(v), mq, mr, mz);
                do_op(4'(d), 2'(v), int'($urandom_range(0, 2)), mq, mr, mz);
            end
        end

        for (int k = 0; k < 40; k++) begin
            rd = 4'($urandom);
            rv = 2'($urandom);
            model(rd, rv, mq, mr, mz);
            do_op(rd, rv, int'($urandom_range(0, 3)), mq, mr, mz);
        end

        @(posedge clk); #1;
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
